keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Behavioural model of a 4x4 passive keypad matrix, synthesisable; it is the responder at the other end of the keypad scanner interface.
- Watches the column lines driven by the scanner and drives the row lines back, as a pressed key would.
- Takes press commands (key index, hold time) through a valid/ready handshake and models contact bounce on press and on release.
- Used for on-board self-test of the scanner/debounce/number-bank path and as the bench stimulus source.

Parameters:
- HOLD_W, 16, width of the hold-time field in cycles
- BOUNCE_CYCLES, 1000, length of each bounce window (press and release), cycles, >= BOUNCE_STEP
- BOUNCE_STEP, 8, cycles between contact re-evaluations inside a bounce window, >= 1
- LFSR_SEED, 16'hACE1, nonzero reset value of the bounce LFSR

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- C  in  4  column drive from the scanner, active-low (column i is selected when C[i]=0)
- R  out  4  row lines to the scanner, active-low (R[j]=0 means row j is pulled to a selected column)
- cmd_valid  in  1  press request valid
- cmd_key  in  4  key index; row = cmd_key[3:2], column = cmd_key[1:0]
- cmd_hold  in  HOLD_W  cycles the contact is held solidly closed
- cmd_ready  out  1  emulator can accept a command
- busy  out  1  a press is in progress
- done  out  1  one-cycle pulse when a press completes
- contact  out  1  current modelled contact state (1 = closed), for debug

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, contact=0, R=4'b1111, done=0, busy=0, LFSR=LFSR_SEED.
  - cmd_ready=0 while reset is high.
  - Reset mid-press aborts immediately: no done pulse, and the latched key is discarded.
- R is combinational from C and registered state:
  - R[j]=0 iff contact=1, j equals the latched row, and C[latched col]=0. All other rows are 1.
  - Multiple low columns follow the same rule. C is never registered here.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - A command is accepted on the edge where cmd_valid and cmd_ready are both 1; key and hold are latched on that edge.
  - cmd_valid outside IDLE is ignored, with no queueing.
  - cmd_hold=0 is treated as 1.
- busy=1 in every state except IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle, including IDLE.
- FSM states:
  - IDLE -> BOUNCE_PRESS on accept. Bounce counter and step counter are cleared.
  - BOUNCE_PRESS:
    - On the first cycle and every BOUNCE_STEP cycles after, contact <= LFSR[0].
    - After BOUNCE_CYCLES cycles, go to HOLD with contact forced to 1.
  - HOLD: contact=1 for exactly the latched hold cycles, then go to BOUNCE_RELEASE.
  - BOUNCE_RELEASE:
    - Same sampling rule as BOUNCE_PRESS.
    - After BOUNCE_CYCLES cycles, contact is forced to 0, state goes to IDLE, and done=1 for that one cycle.
- Boundary cases:
  - A command presented in the same cycle done pulses is not accepted, because cmd_ready is still 0. It is accepted on the next cycle.
  - Hold counter is HOLD_W bits; the maximum hold 2^HOLD_W-1 must not wrap.
  - C may change at any time; R tracks it in the same cycle.

Optional Feature:
- Macro KEYPAD_EMU_BOUNCE_EN.
- Defined: bounce states behave as above.
- Undefined:
  - Bounce states are skipped. IDLE -> HOLD on accept, with contact=1 from the cycle after accept.
  - After the hold count, contact=0, IDLE, and done pulses in that first open cycle.
  - The LFSR is not instantiated, and BOUNCE_CYCLES/BOUNCE_STEP are unused.

Test Plan:
- Reset, then C cycling 1110,1101,1011,0111 with no command -> R=1111 always; cmd_ready=1, busy=0, done=0.
- Clean build (macro undefined), cmd_key=4'h6, cmd_hold=20, C held 1011 -> R=1101 for exactly 20 cycles starting the cycle after accept. Then R=1111 and a single done pulse; total busy = 20 cycles.
- Bounce build, BOUNCE_CYCLES=40, BOUNCE_STEP=4, cmd_key=4'h0, cmd_hold=100, C=1110:
  - contact changes only on 4-cycle boundaries within the 40-cycle windows;
  - contact is solidly 1 for 100 cycles;
  - done arrives 180 cycles after accept.
- Latched key 4'h6 with a scanner-style rotating C -> R[1]=0 only in cycles where C=1011. cmd_key=4'hF -> R[3]=0 only when C=0111.
- Issue a command, then assert reset 10 cycles into HOLD -> R=1111 and contact=0 the cycle after reset; no done pulse; cmd_ready=1 after reset deasserts.
- Hold cmd_valid high continuously with cmd_hold=0 -> hold treated as 1 cycle; back-to-back presses are accepted on the cycle after each done, never during busy.

Source files
------------

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_emulator
//  Description : Synthesisable model of a 4x4 passive keypad matrix. Accepts
//                press commands (key index, hold time) over valid/ready and
//                pulls the selected row low while the modelled contact is
//                closed and the scanner drives that key's column low.
//                Optional contact-bounce modelling on press and release is
//                enabled by defining the macro KEYPAD_EMU_BOUNCE_EN; when it
//                is undefined the contact closes and opens cleanly.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_emulator #(
    parameter int          HOLD_W        = 16,
    parameter int          BOUNCE_CYCLES = 1000,
    parameter int          BOUNCE_STEP   = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        C,
    output logic [3:0]        R,
    input  logic              cmd_valid,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              cmd_ready,
    output logic              busy,
    output logic              done,
    output logic              contact
);

    // A configuration that breaks the bounce timing rules, or an all-zero
    // LFSR seed, leaves the emulator permanently refusing commands rather
    // than producing a malformed press.
    localparam logic CFG_OK = (BOUNCE_STEP >= 1) &&
                              (BOUNCE_CYCLES >= BOUNCE_STEP) &&
                              (LFSR_SEED != 16'h0000);

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        BOUNCE_PRESS   = 2'd1,
        HOLD           = 2'd2,
        BOUNCE_RELEASE = 2'd3
    } state_t;

    state_t            state_q;
    logic              contact_q;
    logic              done_q;
    logic [1:0]        row_q;
    logic [1:0]        col_q;
    logic [HOLD_W-1:0] hold_cnt_q;

    logic              w_accept;
    logic [HOLD_W-1:0] w_hold_load;

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int BCNT_W = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam int STEP_W = (BOUNCE_STEP > 1)   ? $clog2(BOUNCE_STEP)   : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(BOUNCE_STEP - 1);

    logic [15:0]       lfsr_q;
    logic [BCNT_W-1:0] bcnt_q;
    logic [STEP_W-1:0] step_q;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) supplying bounce noise
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
`endif

    // The done cycle is already IDLE but must still refuse a new command
    assign cmd_ready   = (state_q == IDLE) && !done_q && !reset && CFG_OK;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_hold_load = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign contact     = contact_q;

    // Row drive: purely combinational from the live column lines so the
    // scanner sees the key in the same cycle it selects the column
    always_comb begin
        R = 4'b1111;
        if (contact_q && !C[col_q]) begin
            R[row_q] = 1'b0;
        end
    end

    // Press sequencer: latches the command, times bounce and hold windows
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            contact_q  <= 1'b0;
            done_q     <= 1'b0;
            row_q      <= 2'd0;
            col_q      <= 2'd0;
            hold_cnt_q <= '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            bcnt_q     <= '0;
            step_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        row_q      <= cmd_key[3:2];
                        col_q      <= cmd_key[1:0];
                        hold_cnt_q <= w_hold_load;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        state_q    <= BOUNCE_PRESS;
                        bcnt_q     <= '0;
                        step_q     <= '0;
`else
                        state_q    <= HOLD;
                        contact_q  <= 1'b1;
`endif
                    end
                end

                HOLD: begin
                    // Counter stops at 1, so the maximum hold never wraps
                    if (hold_cnt_q == HOLD_W'(1)) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                        state_q   <= BOUNCE_RELEASE;
                        bcnt_q    <= '0;
                        step_q    <= '0;
`else
                        state_q   <= IDLE;
                        contact_q <= 1'b0;
                        done_q    <= 1'b1;
`endif
                    end else begin
                        hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                    end
                end

`ifdef KEYPAD_EMU_BOUNCE_EN
                BOUNCE_PRESS: begin
                    if (bcnt_q == BCNT_LAST) begin
                        state_q   <= HOLD;
                        contact_q <= 1'b1;
                    end else begin
                        bcnt_q <= bcnt_q + BCNT_W'(1);
                        if (step_q == '0) begin
                            contact_q <= lfsr_q[0];
                        end
                        step_q <= (step_q == STEP_LAST) ? '0 : step_q + STEP_W'(1);
                    end
                end

                BOUNCE_RELEASE: begin
                    if (bcnt_q == BCNT_LAST) begin
                        state_q   <= IDLE;
                        contact_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        bcnt_q <= bcnt_q + BCNT_W'(1);
                        if (step_q == '0) begin
                            contact_q <= lfsr_q[0];
                        end
                        step_q <= (step_q == STEP_LAST) ? '0 : step_q + STEP_W'(1);
                    end
                end
`endif

                default: begin
                    state_q   <= IDLE;
                    contact_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_emulator
//  Description : Directed self-checking bench for keypad_emulator. Covers the
//                clean build by default and the bounce trace when
//                KEYPAD_EMU_BOUNCE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

    localparam int HW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    C;
    logic [3:0]    R;
    logic          cmd_valid;
    logic [3:0]    cmd_key;
    logic [HW-1:0] cmd_hold;
    logic          cmd_ready;
    logic          busy;
    logic          done;
    logic          contact;

    int tests = 0;
    int fails = 0;

    logic [3:0] cpat [5];

    keypad_emulator #(
        .HOLD_W        (HW),
        .BOUNCE_CYCLES (40),
        .BOUNCE_STEP   (4),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .C         (C),
        .R         (R),
        .cmd_valid (cmd_valid),
        .cmd_key   (cmd_key),
        .cmd_hold  (cmd_hold),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .done      (done),
        .contact   (contact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_r(input logic [3:0] key, input logic [3:0] c, input logic closed);
        logic [3:0] r;
        r = 4'b1111;
        if (closed && !c[key[1:0]]) r[key[3:2]] = 1'b0;
        return r;
    endfunction

    // Present a command while idle; returns just after the accepting edge
    task automatic send(input logic [3:0] key, input logic [HW-1:0] hold);
        cmd_key   = key;
        cmd_hold  = hold;
        cmd_valid = 1'b1;
        #1;
        chk("send_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max) begin
            step();
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic prev;
        cpat[0] = 4'b1110; cpat[1] = 4'b1101; cpat[2] = 4'b1011;
        cpat[3] = 4'b0111; cpat[4] = 4'b0000;

        reset = 1'b1; C = 4'b1111; cmd_valid = 1'b0; cmd_key = 4'h0; cmd_hold = '0;
        step(); step();
        chk("rst_R",       R,         4'b1111);
        chk("rst_contact", contact,   0);
        chk("rst_busy",    busy,      0);
        chk("rst_done",    done,      0);
        chk("rst_ready",   cmd_ready, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", cmd_ready, 1);

        // Idle: rotating columns never produce a row
        for (int i = 0; i < 4; i++) begin
            C = cpat[i];
            step();
            chk("idle_R",     R,         4'b1111);
            chk("idle_busy",  busy,      0);
            chk("idle_done",  done,      0);
            chk("idle_ready", cmd_ready, 1);
        end

`ifndef KEYPAD_EMU_BOUNCE_EN
        // Key 6, hold 20, column 2 selected: row 1 low for exactly 20 cycles
        C = 4'b1011;
        send(4'h6, 8'd20);
        for (int i = 0; i < 20; i++) begin
            chk("k6_R",     R,         4'b1101);
            chk("k6_busy",  busy,      1);
            chk("k6_ready", cmd_ready, 0);
            step();
        end
        chk("k6_end_R",     R,         4'b1111);
        chk("k6_end_done",  done,      1);
        chk("k6_end_busy",  busy,      0);
        chk("k6_end_ready", cmd_ready, 0);
        // Command presented in the done cycle waits one more cycle
        cmd_key = 4'h5; cmd_hold = 8'd3; cmd_valid = 1'b1;
        step();
        chk("donecyc_not_taken", busy,      0);
        chk("donecyc_ready",     cmd_ready, 1);
        chk("donecyc_done",      done,      0);
        step();
        cmd_valid = 1'b0;
        chk("nextcyc_taken", busy, 1);
        wait_done(10);
        step();

        // Key 6 under a scanner-style rotating C, checked within each cycle
        send(4'h6, 8'd8);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 5; j++) begin
                C = cpat[j];
                #1;
                chk("rot6_R", R, exp_r(4'h6, cpat[j], 1'b1));
            end
            step();
        end
        chk("rot6_done", done, 1);
        step();

        // Key F: row 3 only while column 3 is selected
        send(4'hF, 8'd4);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 5; j++) begin
                C = cpat[j];
                #1;
                chk("rotF_R", R, exp_r(4'hF, cpat[j], 1'b1));
            end
            step();
        end
        chk("rotF_done", done, 1);
        C = 4'b0111;
        #1;
        chk("rotF_after_R", R, 4'b1111);
        step();

        // Reset ten cycles into hold aborts the press silently
        C = 4'b1110;
        send(4'h0, 8'd50);
        for (int i = 0; i < 9; i++) step();
        chk("abort_pre_R", R, 4'b1110);
        reset = 1'b1;
        step();
        chk("abort_R",       R,         4'b1111);
        chk("abort_contact", contact,   0);
        chk("abort_busy",    busy,      0);
        chk("abort_done",    done,      0);
        chk("abort_ready",   cmd_ready, 0);
        reset = 1'b0;
        #1;
        chk("abort_ready_after", cmd_ready, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_no_done", done, 0);
            chk("abort_idle_R",  R,    4'b1111);
        end

        // Maximum hold 2^HW-1 does not wrap
        C = 4'b0111;
        send(4'h3, 8'hFF);
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            step();
        end
        chk("maxhold_len",  n,    255);
        chk("maxhold_done", done, 1);
        step();

        // cmd_valid held high with hold 0: one-cycle presses back to back
        cmd_key = 4'h5; cmd_hold = 8'd0; cmd_valid = 1'b1;
        for (int r = 0; r < 3; r++) begin
            step();
            chk("b2b_busy",     busy,      1);
            chk("b2b_contact",  contact,   1);
            chk("b2b_ready",    cmd_ready, 0);
            step();
            chk("b2b_done",     done,      1);
            chk("b2b_done_bsy", busy,      0);
            chk("b2b_done_rdy", cmd_ready, 0);
            step();
            chk("b2b_idle_rdy", cmd_ready, 1);
            chk("b2b_idle_bsy", busy,      0);
            chk("b2b_idle_dn",  done,      0);
        end
        cmd_valid = 1'b0;
        step();
        chk("b2b_stop", busy, 0);
`else
        // Bounce trace: 40-cycle windows, 4-cycle sampling grid, hold 100
        C = 4'b1110;
        send(4'h0, 8'd100);
        prev = contact;
        for (int k = 1; k <= 180; k++) begin
            step();
            if (k >= 40 && k < 140) begin
                chk("bnc_hold_contact", contact, 1);
                chk("bnc_hold_R",       R,       4'b1110);
            end else if (k < 180) begin
                chk("bnc_grid", (contact !== prev) && (k % 4 != 1), 0);
            end
            chk("bnc_done", done, (k == 180) ? 1 : 0);
            chk("bnc_busy", busy, (k < 180) ? 1 : 0);
            prev = contact;
        end
        chk("bnc_end_contact", contact, 0);
        step();
        chk("bnc_ready", cmd_ready, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
